// File: rtl/alu_seq_if.sv
// Bus between the EX-stage control FSM (master) and the sequential ALU (slave).
//
// Handshake: the master may raise start with ALUControl/rs/rt at any edge.
// The request is taken only at an edge where busy=0; while busy=1 it is
// dropped, not queued. done is a single-cycle pulse that follows completion
// and marks ALUOut/flags/hi/lo as valid. A single-cycle op pulses done in the
// cycle after acceptance, so back-to-back starts give back-to-back done pulses.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] ALUOut;
    logic             zero;
    logic             overflow;
    logic             div0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       state_dbg;

    modport master (
        output start, ALUControl, rs, rt,
        input  ALUOut, zero, overflow, div0, busy, done, hi, lo, state_dbg
    );

    modport slave (
        input  start, ALUControl, rs, rt,
        output ALUOut, zero, overflow, div0, busy, done, hi, lo, state_dbg
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential EX-stage ALU: single-cycle logic/arith/compare ops plus an
// iterative unsigned shift-add multiplier and restoring divider that write
// the HI/LO register pair. FSM state is exported on bus.state_dbg.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             ov_q, ov_d;
    logic             d0_q, d0_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // a: multiplicand / divisor; b: multiplier / dividend-then-quotient;
    // acc: upper partial product / partial remainder
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] rs, rt;
    logic [WIDTH-1:0] add_res, sub_res;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] div_rem;
    logic             div_qbit;
    logic             last_step;

    assign rs = bus.rs;
    assign rt = bus.rt;

    // Per-step datapath shared by the single-cycle ops and the iterative unit
    always_comb begin
        add_res   = rs + rt;
        sub_res   = rs - rt;
        mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
        div_shift = {acc_q, b_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, a_q};
        div_qbit  = ~div_trial[WIDTH];
        div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state: accept requests in IDLE, iterate in MUL/DIV
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ov_d    = ov_q;
        d0_d    = d0_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.ALUControl == OP_MUL || bus.ALUControl == OP_DIV) begin
                        // Flags hold until completion; operands are latched here
                        state_d = (bus.ALUControl == OP_MUL) ? ST_MUL : ST_DIV;
                        a_d     = (bus.ALUControl == OP_MUL) ? rs : rt;
                        b_d     = (bus.ALUControl == OP_MUL) ? rt : rs;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                        ov_d   = 1'b0;
                        d0_d   = 1'b0;
                        case (bus.ALUControl)
                            OP_AND:  out_d = rs & rt;
                            OP_OR:   out_d = rs | rt;
                            OP_ADD: begin
                                out_d = add_res;
                                ov_d  = (rs[WIDTH-1] == rt[WIDTH-1]) && (add_res[WIDTH-1] != rs[WIDTH-1]);
                            end
                            OP_SUB: begin
                                out_d = sub_res;
                                ov_d  = (rs[WIDTH-1] != rt[WIDTH-1]) && (sub_res[WIDTH-1] != rs[WIDTH-1]);
                            end
                            OP_SLT:  out_d = {{(WIDTH - 1){1'b0}}, ($signed(rs) < $signed(rt))};
                            OP_SLTU: out_d = {{(WIDTH - 1){1'b0}}, (rs < rt)};
                            OP_NOR:  out_d = ~(rs | rt);
                            OP_MFHI: out_d = hi_q;
                            OP_MFLO: out_d = lo_q;
                            default: out_d = '0;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                b_d   = {mul_sum[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d    = mul_sum[WIDTH:1];
                    lo_d    = {mul_sum[0], b_q[WIDTH-1:1]};
                    out_d   = {mul_sum[0], b_q[WIDTH-1:1]};
                    ov_d    = 1'b0;
                    d0_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (a_q == '0) begin
                    // Divide by zero: no iteration, quotient saturates
                    hi_d    = b_q;
                    lo_d    = '1;
                    out_d   = '1;
                    ov_d    = 1'b0;
                    d0_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = div_rem;
                    b_d   = {b_q[WIDTH-2:0], div_qbit};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        hi_d    = div_rem;
                        lo_d    = {b_q[WIDTH-2:0], div_qbit};
                        out_d   = {b_q[WIDTH-2:0], div_qbit};
                        ov_d    = 1'b0;
                        d0_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; async reset aborts any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ov_q    <= 1'b0;
            d0_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ov_q    <= ov_d;
            d0_q    <= d0_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.ALUOut    = out_q;
    assign bus.zero      = (out_q == '0);
    assign bus.overflow  = ov_q;
    assign bus.div0      = d0_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit and an 8-bit instance share clock and reset.
// A cycle-level reference model computes results with plain arithmetic and a
// latency countdown; directed cases pin it with hand-computed literals.
module tb_alu_seq;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef struct packed {
        logic        ov;
        logic [63:0] res;
    } sres_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Uniform views of both instances
    logic        i_start [2];
    logic [3:0]  i_op    [2];
    logic [63:0] i_rs    [2];
    logic [63:0] i_rt    [2];
    logic [63:0] o_out   [2];
    logic [63:0] o_hi    [2];
    logic [63:0] o_lo    [2];
    logic        o_busy  [2];
    logic        o_done  [2];
    logic        o_zero  [2];
    logic        o_ov    [2];
    logic        o_d0    [2];

    assign i_start[0] = bus32.start;
    assign i_start[1] = bus8.start;
    assign i_op[0]    = bus32.ALUControl;
    assign i_op[1]    = bus8.ALUControl;
    assign i_rs[0]    = 64'(bus32.rs);
    assign i_rs[1]    = 64'(bus8.rs);
    assign i_rt[0]    = 64'(bus32.rt);
    assign i_rt[1]    = 64'(bus8.rt);
    assign o_out[0]   = 64'(bus32.ALUOut);
    assign o_out[1]   = 64'(bus8.ALUOut);
    assign o_hi[0]    = 64'(bus32.hi);
    assign o_hi[1]    = 64'(bus8.hi);
    assign o_lo[0]    = 64'(bus32.lo);
    assign o_lo[1]    = 64'(bus8.lo);
    assign o_busy[0]  = bus32.busy;
    assign o_busy[1]  = bus8.busy;
    assign o_done[0]  = bus32.done;
    assign o_done[1]  = bus8.done;
    assign o_zero[0]  = bus32.zero;
    assign o_zero[1]  = bus8.zero;
    assign o_ov[0]    = bus32.overflow;
    assign o_ov[1]    = bus8.overflow;
    assign o_d0[0]    = bus32.div0;
    assign o_d0[1]    = bus8.div0;

    function automatic int wid(int u);
        return (u == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] mask_of(int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sval(logic [63:0] v, int w);
        if (v[w-1]) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    // Result of a single-cycle op from its arithmetic definition
    function automatic sres_t single_op(logic [3:0] op, logic [63:0] a, logic [63:0] b,
                                        logic [63:0] hi, logic [63:0] lo, int w);
        sres_t  r;
        longint t;
        longint smax;
        longint smin;
        logic [63:0] m;
        m    = mask_of(w);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        r.ov = 1'b0;
        case (op)
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_NOR:  r.res = ~(a | b) & m;
            OP_ADD: begin
                t     = sval(a, w) + sval(b, w);
                r.res = (a + b) & m;
                r.ov  = (t > smax) || (t < smin);
            end
            OP_SUB: begin
                t     = sval(a, w) - sval(b, w);
                r.res = (a - b) & m;
                r.ov  = (t > smax) || (t < smin);
            end
            OP_SLT:  r.res = (sval(a, w) < sval(b, w)) ? 64'd1 : 64'd0;
            OP_SLTU: r.res = (a < b) ? 64'd1 : 64'd0;
            OP_MFHI: r.res = hi;
            OP_MFLO: r.res = lo;
            default: r.res = 64'd0;
        endcase
        return r;
    endfunction

    // Reference model: architectural registers plus a latency countdown
    logic        m_busy [2];
    logic        m_done [2];
    logic        m_ov   [2];
    logic        m_d0   [2];
    logic        m_pd0  [2];
    logic [63:0] m_out  [2];
    logic [63:0] m_hi   [2];
    logic [63:0] m_lo   [2];
    logic [63:0] m_phi  [2];
    logic [63:0] m_plo  [2];
    int          m_left [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_busy[u] <= 1'b0;
                m_done[u] <= 1'b0;
                m_ov[u]   <= 1'b0;
                m_d0[u]   <= 1'b0;
                m_pd0[u]  <= 1'b0;
                m_out[u]  <= 64'd0;
                m_hi[u]   <= 64'd0;
                m_lo[u]   <= 64'd0;
                m_phi[u]  <= 64'd0;
                m_plo[u]  <= 64'd0;
                m_left[u] <= 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_done[u] <= 1'b0;
                if (m_busy[u]) begin
                    if (m_left[u] == 1) begin
                        m_busy[u] <= 1'b0;
                        m_done[u] <= 1'b1;
                        m_hi[u]   <= m_phi[u];
                        m_lo[u]   <= m_plo[u];
                        m_out[u]  <= m_plo[u];
                        m_ov[u]   <= 1'b0;
                        m_d0[u]   <= m_pd0[u];
                    end else begin
                        m_left[u] <= m_left[u] - 1;
                    end
                end else if (i_start[u]) begin
                    if (i_op[u] == OP_MUL) begin
                        m_busy[u] <= 1'b1;
                        m_left[u] <= wid(u);
                        m_phi[u]  <= (i_rs[u] * i_rt[u]) >> wid(u);
                        m_plo[u]  <= (i_rs[u] * i_rt[u]) & mask_of(wid(u));
                        m_pd0[u]  <= 1'b0;
                    end else if (i_op[u] == OP_DIV) begin
                        m_busy[u] <= 1'b1;
                        if (i_rt[u] == 64'd0) begin
                            m_left[u] <= 1;
                            m_phi[u]  <= i_rs[u];
                            m_plo[u]  <= mask_of(wid(u));
                            m_pd0[u]  <= 1'b1;
                        end else begin
                            m_left[u] <= wid(u);
                            m_phi[u]  <= i_rs[u] % i_rt[u];
                            m_plo[u]  <= i_rs[u] / i_rt[u];
                            m_pd0[u]  <= 1'b0;
                        end
                    end else begin
                        m_out[u]  <= single_op(i_op[u], i_rs[u], i_rt[u], m_hi[u], m_lo[u], wid(u)).res;
                        m_ov[u]   <= single_op(i_op[u], i_rs[u], i_rt[u], m_hi[u], m_lo[u], wid(u)).ov;
                        m_d0[u]   <= 1'b0;
                        m_done[u] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(int u, string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s got=%h want=%h", u, name, act, exp);
        end
    endtask

    // Compare process: every output of both instances on every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                chk(u, "busy", 64'(o_busy[u]), 64'(m_busy[u]));
                chk(u, "done", 64'(o_done[u]), 64'(m_done[u]));
                chk(u, "ALUOut", o_out[u], m_out[u]);
                chk(u, "zero", 64'(o_zero[u]), (m_out[u] == 64'd0) ? 64'd1 : 64'd0);
                chk(u, "overflow", 64'(o_ov[u]), 64'(m_ov[u]));
                chk(u, "div0", 64'(o_d0[u]), 64'(m_d0[u]));
                chk(u, "hi", o_hi[u], m_hi[u]);
                chk(u, "lo", o_lo[u], m_lo[u]);
            end
        end
    end

    // Driver tasks
    task automatic drive(int u, logic st, logic [3:0] op, logic [63:0] a, logic [63:0] b);
        if (u == 0) begin
            bus32.start      = st;
            bus32.ALUControl = op;
            bus32.rs         = a[31:0];
            bus32.rt         = b[31:0];
        end else begin
            bus8.start      = st;
            bus8.ALUControl = op;
            bus8.rs         = a[7:0];
            bus8.rt         = b[7:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int u, logic [3:0] op, logic [63:0] a, logic [63:0] b);
        drive(u, 1'b1, op, a, b);
        tick();
        drive(u, 1'b0, 4'b0000, 64'd0, 64'd0);
    endtask

    // Check an iterative op completes exactly n cycles after acceptance
    task automatic run_iter(int u, int n, string name);
        for (int i = 1; i <= n; i++) begin
            if (i == 5) drive(u, 1'b1, OP_ADD, 64'd3, 64'd4);
            else        drive(u, 1'b0, 4'b0000, 64'd0, 64'd0);
            tick();
            chk(u, {name, "_busy"}, 64'(o_busy[u]), (i < n) ? 64'd1 : 64'd0);
            chk(u, {name, "_done"}, 64'(o_done[u]), (i < n) ? 64'd0 : 64'd1);
        end
    endtask

    function automatic logic [63:0] rnd_val(int u);
        logic [63:0] m;
        m = mask_of(wid(u));
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1;
            3:       return 64'd1 << (wid(u) - 1);
            4:       return 64'($urandom_range(0, 20));
            default: return 64'($urandom) & m;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 4'b0000, 64'd0, 64'd0);
        drive(1, 1'b0, 4'b0000, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk(u, "rst_out", o_out[u], 64'd0);
            chk(u, "rst_hi", o_hi[u], 64'd0);
            chk(u, "rst_lo", o_lo[u], 64'd0);
            chk(u, "rst_busy", 64'(o_busy[u]), 64'd0);
            chk(u, "rst_done", 64'(o_done[u]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Single-cycle ops on the 32-bit instance
        issue(0, OP_ADD, 64'h7FFF_FFFF, 64'h1);
        chk(0, "add_done", 64'(o_done[0]), 64'd1);
        chk(0, "add_out", o_out[0], 64'h8000_0000);
        chk(0, "add_ov", 64'(o_ov[0]), 64'd1);
        issue(0, OP_SUB, 64'd5, 64'd5);
        chk(0, "sub_zero", 64'(o_zero[0]), 64'd1);
        chk(0, "sub_ov", 64'(o_ov[0]), 64'd0);
        issue(0, OP_SLT, 64'hFFFF_FFFF, 64'd1);
        chk(0, "slt_out", o_out[0], 64'd1);
        issue(0, OP_SLTU, 64'hFFFF_FFFF, 64'd1);
        chk(0, "sltu_out", o_out[0], 64'd0);
        issue(0, OP_NOR, 64'd0, 64'd0);
        chk(0, "nor_out", o_out[0], 64'hFFFF_FFFF);
        issue(0, OP_OR, 64'h00F0, 64'h0F00);
        chk(0, "or_out", o_out[0], 64'h0FF0);
        issue(0, 4'b1111, 64'h1234, 64'h5678);
        chk(0, "undef_out", o_out[0], 64'd0);
        chk(0, "undef_done", 64'(o_done[0]), 64'd1);

        // MUL with a start pulse mid-operation that must be ignored
        issue(0, OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        run_iter(0, 32, "mul");
        chk(0, "mul_hi", o_hi[0], 64'hFFFF_FFFE);
        chk(0, "mul_lo", o_lo[0], 64'h0000_0001);
        chk(0, "mul_out", o_out[0], 64'h0000_0001);
        tick();
        chk(0, "mul_nodone", 64'(o_done[0]), 64'd0);

        // DIV then HI/LO moves
        issue(0, OP_DIV, 64'd100, 64'd7);
        run_iter(0, 32, "div");
        chk(0, "div_lo", o_lo[0], 64'd14);
        chk(0, "div_hi", o_hi[0], 64'd2);
        chk(0, "div_d0", 64'(o_d0[0]), 64'd0);
        issue(0, OP_MFHI, 64'd0, 64'd0);
        chk(0, "mfhi_out", o_out[0], 64'd2);
        issue(0, OP_MFLO, 64'd0, 64'd0);
        chk(0, "mflo_out", o_out[0], 64'd14);

        // DIV by zero
        issue(0, OP_DIV, 64'h1234, 64'd0);
        chk(0, "dz_busy", 64'(o_busy[0]), 64'd1);
        tick();
        chk(0, "dz_done", 64'(o_done[0]), 64'd1);
        chk(0, "dz_lo", o_lo[0], 64'hFFFF_FFFF);
        chk(0, "dz_hi", o_hi[0], 64'h1234);
        chk(0, "dz_d0", 64'(o_d0[0]), 64'd1);
        issue(0, OP_AND, 64'hF0F0, 64'hFFFF);
        chk(0, "and_d0", 64'(o_d0[0]), 64'd0);
        chk(0, "and_out", o_out[0], 64'hF0F0);

        // 8-bit instance: MUL and back-to-back ADDs
        issue(1, OP_MUL, 64'hFF, 64'hFF);
        run_iter(1, 8, "mul8");
        chk(1, "mul8_hi", o_hi[1], 64'hFE);
        chk(1, "mul8_lo", o_lo[1], 64'h01);
        drive(1, 1'b1, OP_ADD, 64'h10, 64'h20);
        tick();
        chk(1, "b2b_done1", 64'(o_done[1]), 64'd1);
        chk(1, "b2b_out1", o_out[1], 64'h30);
        drive(1, 1'b1, OP_ADD, 64'h7F, 64'h01);
        tick();
        chk(1, "b2b_done2", 64'(o_done[1]), 64'd1);
        chk(1, "b2b_out2", o_out[1], 64'h80);
        chk(1, "b2b_ov2", 64'(o_ov[1]), 64'd1);
        drive(1, 1'b0, 4'b0000, 64'd0, 64'd0);
        tick();
        chk(1, "b2b_done3", 64'(o_done[1]), 64'd0);

        // Asynchronous reset in the middle of a MUL
        issue(0, OP_MUL, 64'd3, 64'd5);
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk(0, "arst_out", o_out[0], 64'd0);
        chk(0, "arst_hi", o_hi[0], 64'd0);
        chk(0, "arst_lo", o_lo[0], 64'd0);
        chk(0, "arst_busy", 64'(o_busy[0]), 64'd0);
        chk(0, "arst_done", 64'(o_done[0]), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(0, OP_ADD, 64'd2, 64'd3);
        chk(0, "post_rst_done", 64'(o_done[0]), 64'd1);
        chk(0, "post_rst_out", o_out[0], 64'd5);

        // Random traffic on both instances, including starts while busy
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < 2; u++) begin
                drive(u, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_val(u), rnd_val(u));
            end
            tick();
        end
        drive(0, 1'b0, 4'b0000, 64'd0, 64'd0);
        drive(1, 1'b0, 4'b0000, 64'd0, 64'd0);
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the datapath ALU.
- Adds signed overflow detection, signed/unsigned set-less-than, and an iterative unsigned multiply/divide unit with HI/LO registers.
- Sits in the EX stage of the multi-cycle core. The control FSM drives it through a start/busy/done handshake and reads the registered result.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at rising edge when busy=0
- ALUControl  input  4  operation code, sampled with start
- rs  input  WIDTH  operand A, sampled with start
- rt  input  WIDTH  operand B, sampled with start
- ALUOut  output  WIDTH  registered result
- zero  output  1  ALUOut == 0 (combinational from register)
- overflow  output  1  signed overflow of last ADD/SUB, registered
- div0  output  1  last DIV had rt == 0, registered
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: ALUOut/flags valid
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async): state=IDLE; ALUOut, hi, lo, counter and all flags = 0; done=0; busy=0. Asserting reset mid-multiply/divide aborts the operation with no partial HI/LO update.
- States: IDLE, MUL, DIV.
- Start acceptance: start is ignored while busy=1 (no queueing, no error).
- Single-cycle ops, accepted at edge k: ALUOut, overflow and div0 update at edge k; done=1 for the cycle after edge k. Back-to-back starts are legal, and done stays high on consecutive cycles.
  - 0000 AND
  - 0001 OR
  - 0010 ADD: overflow = operand signs equal and result sign differs
  - 0110 SUB: overflow = operand signs differ and result sign ≠ rs sign
  - 0111 SLT: signed compare, result 1 or 0
  - 0011 SLTU: unsigned compare
  - 1100 NOR
  - 1010 MFHI: ALUOut=hi
  - 1011 MFLO: ALUOut=lo
  - Undefined codes: ALUOut=0, done pulses.
- Flag scope: overflow is cleared by every non-ADD/SUB op. div0 is cleared by every op except DIV.
- MUL (1000), unsigned shift-add:
  - Accepted at edge k: latch operands, busy=1, state=MUL.
  - One partial-product step per edge, k+1 … k+WIDTH.
  - At edge k+WIDTH: {hi,lo}=rs*rt (full 2·WIDTH product), ALUOut=lo, busy=0, done=1 for one cycle, state=IDLE.
  - Total latency WIDTH cycles; next start may be accepted at edge k+WIDTH+1.
- DIV (1001), unsigned restoring division:
  - Same timing as MUL.
  - Result: lo=quotient, hi=remainder, ALUOut=lo.
  - If rt==0 at acceptance: no iteration. At edge k+1: lo=all ones, hi=rs, ALUOut=lo, div0=1, done=1, busy=0.
- MUL/DIV flags: overflow is cleared at completion.
- Stability: hi/lo change only on MUL/DIV completion and reset. ALUOut is stable between done pulses. rs/rt/ALUControl changes while busy have no effect.

Test Plan:
- Reset: rst_n low mid-MUL (cycle 10 of 32) → ALUOut=hi=lo=0, busy=0, done=0 immediately, asynchronously; next ADD works normally.
- Single-cycle ops: ADD 0x7FFFFFFF+1 → ALUOut=0x80000000, overflow=1, done 1 cycle after start; SUB 5-5 → zero=1, overflow=0; SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0; NOR 0,0 → 0xFFFFFFFF; code 1111 → 0.
- MUL: 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 32 cycles after accept edge; busy high those 32 cycles; start pulsed mid-op is ignored.
- DIV: 100/7 → lo=14, hi=2, div0=0 after 32 cycles; then MFHI → ALUOut=2, MFLO → 14.
- DIV by zero: rs=0x1234, rt=0 → done 1 cycle later, lo=0xFFFFFFFF, hi=0x1234, div0=1; following AND clears div0.
- WIDTH=8 instance: MUL 0xFF*0xFF → {hi,lo}=0xFE01 after 8 cycles; back-to-back ADDs → done high on consecutive cycles.
